// File: rtl/frame_addr_gen_pkg.sv
// Shared video constants and the zoom encoding for the camera frame address path.
// Also holds the coordinate mapping used to scale screen position to source position.
package frame_addr_gen_pkg;

    localparam int SRC_W   = 240;
    localparam int SRC_H   = 320;
    localparam int ADDR_W  = 17;
    localparam int COORD_W = 13;
    localparam int HCNT_W  = 11;
    localparam int VCNT_W  = 10;

    typedef enum logic [1:0] {
        ZOOM_1X  = 2'b00,
        ZOOM_2X  = 2'b01,
        ZOOM_83X = 2'b10
    } zoom_e;

    // Screen coordinate to source coordinate; 2'b11 shares the 8/3x path.
    function automatic logic [COORD_W-1:0] map_coord(
        input logic [1:0]         zoom,
        input logic [COORD_W-1:0] c
    );
        logic [COORD_W-1:0] c3;
        c3 = c + (c << 1);
        case (zoom)
            ZOOM_1X: map_coord = c;
            ZOOM_2X: map_coord = c >> 1;
            default: map_coord = c3 >> 3;
        endcase
    endfunction

endpackage

// File: rtl/frame_addr_gen_if.sv
// Video timing bundle (position, syncs, zoom) as seen on either side of the address generator.
interface frame_addr_gen_if;
    import frame_addr_gen_pkg::*;

    logic [1:0]        scale;
    logic [HCNT_W-1:0] hcount;
    logic [VCNT_W-1:0] vcount;
    logic              hsync;
    logic              vsync;
    logic              active_draw;

    modport master (output scale, hcount, vcount, hsync, vsync, active_draw);
    modport slave  (input  scale, hcount, vcount, hsync, vsync, active_draw);

endinterface

// File: rtl/frame_addr_gen_pipe_delay.sv
// Fixed-depth register shift line with synchronous clear, used to align side-band
// signals with frame buffer read data.
module pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // NOTE: every stage is cleared, not just the head, so the outputs read 0
    // right after reset instead of flushing stale pixels for DEPTH cycles.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign d_out = stage_q[DEPTH-1];

endmodule

// File: rtl/frame_addr_gen.sv
// Maps the display raster position to a read address into the 240x320 camera frame
// buffer at 1x, 2x or 8/3x zoom, and delays timing/zoom to line up with the read data.
module frame_addr_gen
    import frame_addr_gen_pkg::*;
#(
    parameter int SRC_W    = frame_addr_gen_pkg::SRC_W,
    parameter int SRC_H    = frame_addr_gen_pkg::SRC_H,
    parameter int BRAM_LAT = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [1:0]        scale_in,
    input  logic [HCNT_W-1:0] hcount_in,
    input  logic [VCNT_W-1:0] vcount_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              active_draw_in,
    output logic [ADDR_W-1:0] addr_out,
    output logic [1:0]        scale_out,
    output logic [HCNT_W-1:0] hcount_out,
    output logic [VCNT_W-1:0] vcount_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              active_draw_out
);

    localparam int SX_W  = $clog2(SRC_W);
    localparam int SY_W  = $clog2(SRC_H);
    localparam int TIM_W = HCNT_W + VCNT_W + 3;

    logic               frame_start;
    logic [1:0]         scale_eff;
    logic [COORD_W-1:0] sx_full;
    logic [COORD_W-1:0] sy_full;
    logic               in_range_d;

    logic [1:0]         scale_q;
    logic [1:0]         scale_s1_q;
    logic [SX_W-1:0]    sx_q;
    logic [SY_W-1:0]    sy_q;
    logic               in_range_q;

    logic [ADDR_W-1:0]  sy_ext;
    logic [ADDR_W-1:0]  row_base;
    logic [ADDR_W-1:0]  addr_d;
    logic [ADDR_W-1:0]  addr_q;

    // Stage 1 combinational: zoom is only taken at (0,0), and that pixel already uses it.
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        frame_start = (hcount_in == '0) && (vcount_in == '0);
        scale_eff   = frame_start ? scale_in : scale_q;
        sx_full     = map_coord(scale_eff, COORD_W'(hcount_in));
        sy_full     = map_coord(scale_eff, COORD_W'(vcount_in));
        in_range_d  = (sx_full < COORD_W'(SRC_W)) && (sy_full < COORD_W'(SRC_H));
    end

    // Stage 2 combinational: row * width + column, multiply-free for the 240-wide frame.
    always_comb begin
        sy_ext = ADDR_W'(sy_q);
        if (SRC_W == 240) begin
            row_base = (sy_ext << 8) - (sy_ext << 4);
        end else begin
            row_base = sy_ext * ADDR_W'(SRC_W);
        end
        addr_d = in_range_q ? (row_base + ADDR_W'(sx_q)) : '0;
    end

    // NOTE: all state updates use <= so every register samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            scale_q    <= 2'b00;
            scale_s1_q <= 2'b00;
            sx_q       <= '0;
            sy_q       <= '0;
            in_range_q <= 1'b0;
            addr_q     <= '0;
        end else begin
            scale_q    <= scale_eff;
            scale_s1_q <= scale_eff;
            sx_q       <= sx_full[SX_W-1:0];
            sy_q       <= sy_full[SY_W-1:0];
            in_range_q <= in_range_d;
            addr_q     <= addr_d;
        end
    end

    assign addr_out = addr_q;

    // Timing is delayed from the inputs; zoom picks up after its stage-1 register.
    logic [TIM_W-1:0] tim_dly;

    pipe_delay #(
        .WIDTH (TIM_W),
        .DEPTH (2 + BRAM_LAT)
    ) u_tim_delay (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .d_in   ({hcount_in, vcount_in, hsync_in, vsync_in, active_draw_in}),
        .d_out  (tim_dly)
    );

    pipe_delay #(
        .WIDTH (2),
        .DEPTH (1 + BRAM_LAT)
    ) u_scale_delay (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .d_in   (scale_s1_q),
        .d_out  (scale_out)
    );

    assign {hcount_out, vcount_out, hsync_out, vsync_out, active_draw_out} = tim_dly;

endmodule
